proc_io_bridge: RTL and testbench
=================================

# proc_io_bridge

I/O responder on the processor's port bus: `req_in`/`addr_in`/`io_in` on the input side, `out_en`/`addr_out`/`io_out` on the output side, plus `itr`. It terminates that bus into 2**NBIOIN buffered input streams and 2**NBIOOU registered output streams, each with a valid/ready handshake. It raises an interrupt pulse when an input stream receives data. It is instantiated next to `processor` in every top level that uses I/O.

## Interface
- NUBITS, 16, data word width (matches processor)
- NBIOIN, 2, input port address bits; NIN = 2**NBIOIN
- NBIOOU, 2, output port address bits; NOUT = 2**NBIOOU
- FDEPTH, 4, entries per input FIFO (power of 2, ≥2)
- ITRMSK, all ones (NIN bits), input ports allowed to raise `itr`
- clk  in  1  clock; one clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- req_in  in  1  processor reads input port `addr_in` this cycle
- addr_in  in  NBIOIN  input port select
- io_in  out  NUBITS  data to processor (processor's `io_in`)
- out_en  in  1  processor writes `io_out` to port `addr_out`
- addr_out  in  NBIOOU  output port select
- io_out  in  NUBITS  data from processor
- itr  out  1  interrupt pulse to processor
- s_data  in  NIN*NUBITS  external input streams, port k at [k*NUBITS +: NUBITS]
- s_valid  in  NIN  input stream valid
- s_ready  out  NIN  input FIFO not full
- m_data  out  NOUT*NUBITS  output stream registers
- m_valid  out  NOUT  output word pending
- m_ready  in  NOUT  downstream accepts
- ovf  out  NOUT  sticky: output overwritten while pending
- udf  out  NIN  sticky: read of empty input port

## Operation
- Input port k has a FIFO with FDEPTH entries. A push happens when `s_valid[k] & s_ready[k]`. `s_ready[k]` = !full.
- `io_in` is combinational: the head of FIFO[`addr_in`], or 0 if that FIFO is empty.
- When `req_in`=1 and FIFO[`addr_in`] is non-empty, the FIFO pops on that edge.
- When `req_in`=1 and FIFO[`addr_in`] is empty, `io_in`=0, nothing pops, and `udf[addr_in]` is set.
- A push and a pop on the same full FIFO in the same cycle is not possible, because ready=0 blocks the push. On a full FIFO the pop proceeds normally.
- A push and a pop on the same non-empty FIFO in the same cycle both happen, and the count is unchanged.
- On an empty FIFO the pop is refused, even if a push happens in the same cycle. The pushed word becomes visible in the next cycle.
- Output port j: `out_en`=1 loads `io_out` into m_data[j] and sets `m_valid[j]`. `m_valid[j]` clears on `m_valid & m_ready`.
- If `out_en` targets j while `m_valid[j]=1` and `m_ready[j]=0`, the new word overwrites the old one, `m_valid` stays 1, and `ovf[j]` is set.
- If `out_en` targets j while `m_valid[j]` and `m_ready[j]` are both 1, the old word transfers, the new word loads, and `m_valid` stays 1 with no ovf.
- `itr` pulses for 1 cycle on the edge after any masked FIFO transitions from empty to non-empty. Several transitions in the same cycle produce one pulse.
- `ovf` and `udf` clear only on reset.

## Timing
- Reset values (asynchronous, immediate):
  - all FIFOs empty
  - `s_ready` = all ones
  - `io_in` = 0
  - `m_data` = 0, `m_valid` = 0
  - `itr` = 0, `ovf` = 0, `udf` = 0
- Input latency: a word pushed at edge t is readable on `io_in` during cycle t+1.
- Output latency: `out_en` at edge t produces `m_valid`=1 and new `m_data` from t+1.
- Interrupt latency: a push into an empty FIFO at edge t gives `itr`=1 during cycle t+1.
- FIFO pointers are log2(FDEPTH) bits and wrap modulo FDEPTH. Count is log2(FDEPTH)+1 bits.
- Reset asserted mid-transfer discards all buffered and pending words. No handshake completes in a cycle in which `rst`=1.

## Structure
- Shared package/header: NIN/NOUT derivations and the port-slice macro for packed stream buses.
- Sub-module `io_fifo` (NUBITS, FDEPTH), instantiated NIN times via generate. It provides push, pop, head, empty, full, and an empty→nonempty strobe.
- Output registers and the itr/sticky logic stay in the top level.

## Test plan
- Reset, then push 0x1234 on port 2 → at t+1 `itr`=1 for one cycle; with `addr_in`=2 and `req_in`=1, `io_in`=0x1234; the FIFO is empty afterwards.
- Push 5 words on port 0 with FDEPTH=4 → `s_ready[0]`=0 after the 4th push; the 5th is held by the source. Four reads return words 1-4 in order.
- `req_in` on empty port 1 → `io_in`=0, `udf[1]`=1 and stays set; the other ports are unaffected.
- `out_en` to port 3 with 0x00AA, `m_ready`=0; then `out_en` with 0x00BB → `m_data[3]`=0x00BB, `ovf[3]`=1. Then `m_ready`=1 → one transfer and `m_valid[3]`=0.
- Simultaneous push and pop on port 0 holding 2 words → count stays 2, order preserved, no `itr`.
- Assert `rst` mid-cycle with data buffered and `m_valid`=1 → all outputs go to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/proc_io_bridge_pkg.sv
// Shared definitions for the processor I/O bridge: port-count helpers and
// the slice macro used to address one word inside a packed stream bus.
`ifndef PROC_IO_BRIDGE_PKG_SV
`define PROC_IO_BRIDGE_PKG_SV

// Word k of a packed bus whose words are w bits wide.
`define PIB_PORT(k, w) ((k)*(w)) +: (w)

package proc_io_bridge_pkg;

  localparam int DEF_NUBITS = 16;
  localparam int DEF_NBIOIN = 2;
  localparam int DEF_NBIOOU = 2;
  localparam int DEF_FDEPTH = 4;

  // Number of ports selected by an address of addr_bits bits.
  function automatic int port_count(input int addr_bits);
    return 1 << addr_bits;
  endfunction

  // Pointer width for a power-of-two FIFO depth (at least one bit).
  function automatic int ptr_bits(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

`endif

// File: rtl/io_fifo.sv
// Single input-stream FIFO. Pushes beyond full and pops of an empty FIFO are
// ignored internally, so the caller may present raw requests. fill_o flags a
// push landing in an empty FIFO (the empty-to-nonempty transition).
module io_fifo
  import proc_io_bridge_pkg::*;
#(
  parameter int NUBITS = DEF_NUBITS,
  parameter int FDEPTH = DEF_FDEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [NUBITS-1:0] din_i,
  output logic [NUBITS-1:0] head_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              fill_o
);

  localparam int AW = ptr_bits(FDEPTH);

  logic [NUBITS-1:0] mem_q [FDEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(FDEPTH));
  assign do_push = push_i & ~full_o;
  // An empty FIFO refuses the pop even if a push lands this same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign fill_o  = do_push & empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

  // Next pointer and occupancy; pointers wrap naturally modulo FDEPTH.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/proc_io_bridge.sv
// Terminates the processor port bus into NIN buffered input streams and NOUT
// registered output streams, with an interrupt pulse on input arrival and
// sticky overflow/underflow flags.
//
// Handshake: on every stream a word moves on a rising clk edge exactly when
// valid and ready are both 1 at that edge; valid never waits on ready, and
// no transfer happens while rst is high.
module proc_io_bridge
  import proc_io_bridge_pkg::*;
#(
  parameter int NUBITS = DEF_NUBITS,
  parameter int NBIOIN = DEF_NBIOIN,
  parameter int NBIOOU = DEF_NBIOOU,
  parameter int FDEPTH = DEF_FDEPTH,
  localparam int NIN   = 1 << NBIOIN,
  localparam int NOUT  = 1 << NBIOOU,
  parameter logic [NIN-1:0] ITRMSK = '1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_in,
  input  logic [NBIOIN-1:0]      addr_in,
  output logic [NUBITS-1:0]      io_in,
  input  logic                   out_en,
  input  logic [NBIOOU-1:0]      addr_out,
  input  logic [NUBITS-1:0]      io_out,
  output logic                   itr,
  input  logic [NIN*NUBITS-1:0]  s_data,
  input  logic [NIN-1:0]         s_valid,
  output logic [NIN-1:0]         s_ready,
  output logic [NOUT*NUBITS-1:0] m_data,
  output logic [NOUT-1:0]        m_valid,
  input  logic [NOUT-1:0]        m_ready,
  output logic [NOUT-1:0]        ovf,
  output logic [NIN-1:0]         udf
);

  logic [NUBITS-1:0] fifo_head [NIN];
  logic [NIN-1:0]    fifo_empty, fifo_full, fifo_fill, fifo_push, fifo_pop;

  logic [NOUT*NUBITS-1:0] m_data_q, m_data_d;
  logic [NOUT-1:0]        m_valid_q, m_valid_d;
  logic [NOUT-1:0]        ovf_q, ovf_d;
  logic [NIN-1:0]         udf_q, udf_d;
  logic                   itr_q, itr_d;

  for (genvar k = 0; k < NIN; k++) begin : g_in
    assign fifo_push[k] = s_valid[k] & ~fifo_full[k];
    assign fifo_pop[k]  = req_in & (addr_in == NBIOIN'(k));
    assign s_ready[k]   = ~fifo_full[k];

    io_fifo #(
      .NUBITS (NUBITS),
      .FDEPTH (FDEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push[k]),
      .pop_i   (fifo_pop[k]),
      .din_i   (s_data[`PIB_PORT(k, NUBITS)]),
      .head_o  (fifo_head[k]),
      .empty_o (fifo_empty[k]),
      .full_o  (fifo_full[k]),
      .fill_o  (fifo_fill[k])
    );
  end

  // Head of the addressed FIFO is already forced to zero when it is empty.
  assign io_in = fifo_head[addr_in];

  // Interrupt, sticky underflow and output-register next state.
  always_comb begin
    itr_d     = |(fifo_fill & ITRMSK);
    udf_d     = udf_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    ovf_d     = ovf_q;
    if (req_in && fifo_empty[addr_in]) udf_d[addr_in] = 1'b1;
    for (int j = 0; j < NOUT; j++) begin
      if (m_valid_q[j] && m_ready[j]) m_valid_d[j] = 1'b0;
      if (out_en && (addr_out == NBIOOU'(j))) begin
        m_data_d[`PIB_PORT(j, NUBITS)] = io_out;
        m_valid_d[j] = 1'b1;
        // Pending word replaced without ever being accepted.
        if (m_valid_q[j] && !m_ready[j]) ovf_d[j] = 1'b1;
      end
    end
  end

  // Output, flag and interrupt registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data_q  <= '0;
      m_valid_q <= '0;
      ovf_q     <= '0;
      udf_q     <= '0;
      itr_q     <= 1'b0;
    end else begin
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      itr_q     <= itr_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign ovf     = ovf_q;
  assign udf     = udf_q;
  assign itr     = itr_q;

endmodule

// File: tb/tb_proc_io_bridge.sv
// Bench for proc_io_bridge with default parameters (16-bit words, 4 input
// ports, 4 output ports, 4-deep FIFOs).
module tb_proc_io_bridge;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_in;
  logic [1:0]    addr_in;
  logic [W-1:0]  io_in;
  logic          out_en;
  logic [1:0]    addr_out;
  logic [W-1:0]  io_out;
  logic          itr;
  logic [4*W-1:0] s_data;
  logic [3:0]    s_valid;
  logic [3:0]    s_ready;
  logic [4*W-1:0] m_data;
  logic [3:0]    m_valid;
  logic [3:0]    m_ready;
  logic [3:0]    ovf;
  logic [3:0]    udf;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];   // words expected on io_in, in read order
  logic [W-1:0] out_q[$];   // words expected to leave on m_data
  logic [W-1:0] exp;

  proc_io_bridge dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .addr_in  (addr_in),
    .io_in    (io_in),
    .out_en   (out_en),
    .addr_out (addr_out),
    .io_out   (io_out),
    .itr      (itr),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .ovf      (ovf),
    .udf      (udf)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Advance one edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_exp();
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else begin
      exp = 'x;
      errors++;
      $display("FAIL scoreboard_in: read with no expected word");
    end
  endtask

  task automatic pop_out();
    if (out_q.size() > 0) exp = out_q.pop_front();
    else begin
      exp = 'x;
      errors++;
      $display("FAIL scoreboard_out: transfer with no expected word");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_in = 0; addr_in = 0; out_en = 0; addr_out = 0; io_out = 0;
    s_data = '0; s_valid = '0; m_ready = '0;
    #2;
    checks++; if (s_ready !== 4'hF) begin errors++; $display("FAIL rst_s_ready: got %h want f", s_ready); end
    checks++; if (io_in !== 16'h0) begin errors++; $display("FAIL rst_io_in: got %h want 0", io_in); end
    checks++; if (m_valid !== 4'h0 || m_data !== '0) begin errors++; $display("FAIL rst_m: valid %h data %h want 0", m_valid, m_data); end
    checks++; if ({itr, ovf, udf} !== 9'h0) begin errors++; $display("FAIL rst_flags: itr %b ovf %h udf %h want 0", itr, ovf, udf); end
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_single_push();
    addr_in = 2'd2;
    s_data[2*W +: W] = 16'h1234; s_valid[2] = 1'b1; exp_q.push_back(16'h1234);
    tick();
    s_valid = '0; #1;
    checks++; if (itr !== 1'b1) begin errors++; $display("FAIL push_itr: got %b want 1", itr); end
    pop_exp();
    checks++; if (io_in !== exp) begin errors++; $display("FAIL push_read: got %h want %h", io_in, exp); end
    req_in = 1'b1;
    tick();
    req_in = 1'b0; #1;
    checks++; if (itr !== 1'b0) begin errors++; $display("FAIL push_itr_pulse: got %b want 0", itr); end
    checks++; if (io_in !== 16'h0) begin errors++; $display("FAIL push_empty_after: got %h want 0", io_in); end
    checks++; if (udf !== 4'h0) begin errors++; $display("FAIL push_udf: got %h want 0", udf); end
  endtask

  task automatic test_fill();
    addr_in = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      s_data[0 +: W] = W'(i); s_valid[0] = 1'b1; exp_q.push_back(W'(i));
      tick();
    end
    s_data[0 +: W] = 16'd5; #1;
    checks++; if (s_ready[0] !== 1'b0) begin errors++; $display("FAIL fill_full: s_ready0 %b want 0", s_ready[0]); end
    tick();
    checks++; if (s_ready !== 4'b1110) begin errors++; $display("FAIL fill_held: s_ready %h want e", s_ready); end
    s_valid = '0;
    req_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; pop_exp();
      checks++; if (io_in !== exp) begin errors++; $display("FAIL fill_read%0d: got %h want %h", i, io_in, exp); end
      tick();
    end
    req_in = 1'b0; #1;
    checks++; if (io_in !== 16'h0 || s_ready !== 4'hF) begin errors++; $display("FAIL fill_drained: io_in %h s_ready %h want 0/f", io_in, s_ready); end
  endtask

  task automatic test_underflow();
    addr_in = 2'd1; req_in = 1'b1; #1;
    checks++; if (io_in !== 16'h0) begin errors++; $display("FAIL udf_io_in: got %h want 0", io_in); end
    tick();
    req_in = 1'b0; #1;
    checks++; if (udf !== 4'b0010) begin errors++; $display("FAIL udf_set: got %h want 2", udf); end
    tick();
    checks++; if (udf !== 4'b0010) begin errors++; $display("FAIL udf_sticky: got %h want 2", udf); end
    // Push and pop in the same cycle on an empty FIFO: pop refused.
    s_data[1*W +: W] = 16'h5555; s_valid[1] = 1'b1; req_in = 1'b1; exp_q.push_back(16'h5555); #1;
    checks++; if (io_in !== 16'h0) begin errors++; $display("FAIL empty_pushpop_io: got %h want 0", io_in); end
    tick();
    s_valid = '0; req_in = 1'b0; #1;
    pop_exp();
    checks++; if (io_in !== exp) begin errors++; $display("FAIL empty_pushpop_kept: got %h want %h", io_in, exp); end
    checks++; if (itr !== 1'b1) begin errors++; $display("FAIL empty_pushpop_itr: got %b want 1", itr); end
    req_in = 1'b1;
    tick();
    req_in = 1'b0; #1;
    checks++; if (io_in !== 16'h0) begin errors++; $display("FAIL udf_drain: got %h want 0", io_in); end
  endtask

  task automatic test_overwrite();
    int xfers;
    addr_out = 2'd3; io_out = 16'h00AA; out_en = 1'b1; m_ready = '0; out_q.push_back(16'h00AA);
    tick();
    io_out = 16'h00BB; void'(out_q.pop_back()); out_q.push_back(16'h00BB);
    tick();
    out_en = 1'b0; #1;
    checks++; if (m_data[3*W +: W] !== 16'h00BB || m_valid[3] !== 1'b1) begin errors++; $display("FAIL ovw_data: data %h valid %b want 00bb/1", m_data[3*W +: W], m_valid[3]); end
    checks++; if (ovf !== 4'b1000) begin errors++; $display("FAIL ovw_ovf: got %h want 8", ovf); end
    m_ready[3] = 1'b1;
    xfers = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (m_valid[3] && m_ready[3]) begin
        xfers++;
        pop_out();
        checks++; if (m_data[3*W +: W] !== exp) begin errors++; $display("FAIL ovw_xfer: got %h want %h", m_data[3*W +: W], exp); end
      end
      tick();
    end
    m_ready = '0; #1;
    checks++; if (xfers !== 1 || m_valid[3] !== 1'b0) begin errors++; $display("FAIL ovw_once: xfers %0d valid %b want 1/0", xfers, m_valid[3]); end
  endtask

  task automatic test_back_to_back();
    addr_out = 2'd2; io_out = 16'h0011; out_en = 1'b1; out_q.push_back(16'h0011);
    tick();
    io_out = 16'h0022; m_ready[2] = 1'b1; #1;
    pop_out();
    checks++; if (!(m_valid[2] === 1'b1 && m_data[2*W +: W] === exp)) begin errors++; $display("FAIL b2b_first: valid %b data %h want 1/%h", m_valid[2], m_data[2*W +: W], exp); end
    out_q.push_back(16'h0022);
    tick();
    out_en = 1'b0; m_ready = '0; #1;
    pop_out();
    checks++; if (!(m_valid[2] === 1'b1 && m_data[2*W +: W] === exp)) begin errors++; $display("FAIL b2b_second: valid %b data %h want 1/%h", m_valid[2], m_data[2*W +: W], exp); end
    checks++; if (ovf !== 4'b1000) begin errors++; $display("FAIL b2b_no_ovf: got %h want 8", ovf); end
    m_ready[2] = 1'b1;
    tick();
    m_ready = '0; #1;
    checks++; if (m_valid !== 4'h0) begin errors++; $display("FAIL b2b_drain: got %h want 0", m_valid); end
  endtask

  task automatic test_push_pop();
    logic [W-1:0] w;
    addr_in = 2'd0;
    for (int i = 0; i < 2; i++) begin
      w = W'($urandom_range(16'h0100, 16'hFFFF));
      s_data[0 +: W] = w; s_valid[0] = 1'b1; exp_q.push_back(w);
      tick();
    end
    w = W'($urandom_range(16'h0100, 16'hFFFF));
    s_data[0 +: W] = w; req_in = 1'b1; #1;
    pop_exp();
    checks++; if (io_in !== exp) begin errors++; $display("FAIL pp_head: got %h want %h", io_in, exp); end
    exp_q.push_back(w);
    tick();
    s_valid = '0; #1;
    checks++; if (itr !== 1'b0) begin errors++; $display("FAIL pp_itr: got %b want 0", itr); end
    for (int i = 0; i < 2; i++) begin
      pop_exp();
      checks++; if (io_in !== exp) begin errors++; $display("FAIL pp_order%0d: got %h want %h", i, io_in, exp); end
      tick();
    end
    req_in = 1'b0; #1;
    checks++; if (io_in !== 16'h0 || udf !== 4'b0010) begin errors++; $display("FAIL pp_count: io_in %h udf %h want 0/2", io_in, udf); end
  endtask

  task automatic test_async_reset();
    addr_in = 2'd3;
    s_data[3*W +: W] = 16'h7777; s_valid[3] = 1'b1;
    addr_out = 2'd0; io_out = 16'h003C; out_en = 1'b1;
    tick();
    s_valid = '0; out_en = 1'b0; #1;
    checks++; if (io_in !== 16'h7777 || m_valid[0] !== 1'b1) begin errors++; $display("FAIL ar_setup: io_in %h valid %b want 7777/1", io_in, m_valid[0]); end
    #1 rst = 1'b1;
    #1;
    checks++; if (io_in !== 16'h0 || s_ready !== 4'hF) begin errors++; $display("FAIL ar_in: io_in %h s_ready %h want 0/f", io_in, s_ready); end
    checks++; if (m_valid !== 4'h0 || m_data !== '0) begin errors++; $display("FAIL ar_out: valid %h data %h want 0", m_valid, m_data); end
    checks++; if ({itr, ovf, udf} !== 9'h0) begin errors++; $display("FAIL ar_flags: itr %b ovf %h udf %h want 0", itr, ovf, udf); end
    exp_q.delete(); out_q.delete();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (io_in !== 16'h0 || m_valid !== 4'h0) begin errors++; $display("FAIL ar_after: io_in %h valid %h want 0/0", io_in, m_valid); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill();
    test_underflow();
    test_overwrite();
    test_back_to_back();
    test_push_pop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
